wb_port_arbiter: RTL and testbench
==================================

# wb_port_arbiter

Arbitrates the single register-file write port between the in-order pipeline writeback stream (requester A) and the long-latency multi-cycle unit (requester B). It drives the 2:1 destination/data select, registers the winning write, and stalls the pipeline when B must win. It sits between the MEM/WB boundary and the register file. It guarantees bounded waiting for B and correct write-after-write (WAW) ordering on equal destination registers.

## Interface
- DATA_W, 32, write data width
- ADDR_W, 5, register address width
- MAX_WAIT, 4, blocked cycles B tolerates before forced grant (≥1)
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- a_valid  in  1  pipeline writeback request (no ready; held by stall_o)
- a_rd  in  ADDR_W  pipeline destination register
- a_data  in  DATA_W  pipeline result
- b_valid  in  1  multi-cycle unit result valid
- b_rd  in  ADDR_W  multi-cycle destination register
- b_data  in  DATA_W  multi-cycle result
- b_ready  out  1  B accepted this cycle (combinational)
- stall_o  out  1  pipeline must hold A this cycle (combinational)
- wb_we  out  1  register-file write enable (registered)
- wb_addr  out  ADDR_W  register-file write address (registered)
- wb_data  out  DATA_W  register-file write data (registered)
- wb_sel  out  1  source of current write: 0 = A, 1 = B (registered)

## Operation
- B is always older than any concurrently valid A; A is never dropped.
- FSM states: NORMAL, STARVED. Counter wait_cnt, range 0..MAX_WAIT, saturating.
- NORMAL:
  - A has priority.
  - grant_a = a_valid. grant_b = b_valid & !a_valid.
  - WAW case: a_valid & b_valid & a_rd == b_rd. A is granted and B is retired with b_ready = 1. B's write is discarded. wait_cnt clears.
- STARVED:
  - grant_b = b_valid. grant_a = 0.
  - stall_o = a_valid.
  - Always returns to NORMAL next cycle.
- Transition NORMAL→STARVED: b_valid & !b_ready & wait_cnt == MAX_WAIT-1.
- wait_cnt rules:
  - Increments when b_valid & !b_ready.
  - Clears when b_ready or !b_valid.
- b_ready = grant_b, or the WAW discard case.
- stall_o is 0 in NORMAL.
- Write register update each cycle:
  - wb_we = grant with rd != 0.
  - wb_addr/wb_data/wb_sel come from the granted source; wb_sel = 1 iff B granted.
  - With no grant: wb_we = 0; addr/data/sel hold.
- Writes to register 0 are granted and retired but never enabled.

## Timing
- Reset (async): state NORMAL, wait_cnt 0, wb_we 0, wb_addr 0, wb_data 0, wb_sel 0. b_ready and stall_o are 0 while rst is high.
- Latency: granted request → wb_* valid on the next rising edge (1 cycle). Register-file write occurs on the edge after that.
- Handshake: B must hold b_valid/b_rd/b_data stable until b_ready. A is held by the pipeline while stall_o = 1.
- Worst-case B wait: MAX_WAIT cycles of b_valid before b_ready.
- Reset mid-STARVED: state abandons immediately. The pending B is re-arbitrated from wait_cnt 0 after release.
- b_valid drops while STARVED (illegal, tolerated): no grant, no stall, return to NORMAL.

## Structure
- Shared package holds:
  - state encoding (NORMAL = 0, STARVED = 1);
  - constant REG_ZERO = 0;
  - WB_SEL_A = 0, WB_SEL_B = 1.
- Data/address selection instantiates the existing 2:1 32-bit select block mux_dst (a second instance at ADDR_W for address, or a local select). The FSM, counter and output register stay in this module.

## Test plan
- A only: a_valid = 1, a_rd = 3, a_data = 0x11 → next cycle wb_we = 1, wb_addr = 3, wb_data = 0x11, wb_sel = 0; b_ready = 0, stall_o = 0.
- B only: b_valid = 1, b_rd = 7, b_data = 0xBEEF → b_ready = 1 same cycle; next cycle wb_we = 1, wb_addr = 7, wb_sel = 1.
- Starvation, MAX_WAIT = 4: a_valid held high, b_valid high from cycle 0 → b_ready = 0 for cycles 0–3. Cycle 4: b_ready = 1, stall_o = 1. Cycle 5: wb_sel = 1, then A resumes.
- WAW: a_rd = b_rd = 9, a_data = 0xA, b_data = 0xB → b_ready = 1; next cycle single write wb_addr = 9, wb_data = 0xA, wb_sel = 0.
- Register 0: b_rd = 0 → b_ready = 1, wb_we = 0 next cycle.
- Async reset asserted mid-STARVED → all wb_* = 0 and stall_o = 0 without a clock edge. After release with A and B valid, B waits a full MAX_WAIT cycles again.

Source files
------------

// File: rtl/wb_port_arbiter_pkg.sv
// Shared encodings for the register-file write-port arbiter.
package wb_port_arbiter_pkg;

    typedef enum logic {
        NORMAL  = 1'b0,
        STARVED = 1'b1
    } arb_state_e;

    localparam int   REG_ZERO = 0;
    localparam logic WB_SEL_A = 1'b0;
    localparam logic WB_SEL_B = 1'b1;

endpackage

// File: rtl/mux_dst.sv
// 2:1 destination/data select; sel = 1 picks d1.
module mux_dst #(
    parameter int W = 32
) (
    input  logic         sel,
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    output logic [W-1:0] y
);

    assign y = sel ? d1 : d0;

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the register-file write port between the pipeline writeback (A)
// and the multi-cycle unit (B), with bounded B waiting and WAW discard.
module wb_port_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    input  logic [ADDR_W-1:0] a_rd,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    input  logic [ADDR_W-1:0] b_rd,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic              stall_o,
    output logic              wb_we,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_sel
);
    import wb_port_arbiter_pkg::*;

    localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT + 1) : 1;

    arb_state_e        state, state_nx;
    logic [CNT_W-1:0]  wait_cnt, wait_cnt_nx;
    logic              grant_a, grant_b;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    mux_dst #(.W(DATA_W)) u_mux_data (
        .sel (grant_b),
        .d0  (a_data),
        .d1  (b_data),
        .y   (sel_data)
    );

    mux_dst #(.W(ADDR_W)) u_mux_addr (
        .sel (grant_b),
        .d0  (a_rd),
        .d1  (b_rd),
        .y   (sel_addr)
    );

    always_comb begin
        state_nx = state;
        grant_a  = 1'b0;
        grant_b  = 1'b0;
        b_ready  = 1'b0;
        stall_o  = 1'b0;
        if (!rst) begin
            case (state)
                NORMAL: begin
                    grant_a = a_valid;
                    grant_b = b_valid & ~a_valid;
                    // Same-destination collision: the younger A write supersedes B.
                    b_ready = grant_b | (a_valid & b_valid & (a_rd == b_rd));
                    if (b_valid && !b_ready && wait_cnt == CNT_W'(MAX_WAIT - 1))
                        state_nx = STARVED;
                end
                STARVED: begin
                    grant_b  = b_valid;
                    b_ready  = b_valid;
                    stall_o  = a_valid & b_valid;
                    state_nx = NORMAL;
                end
                default: state_nx = NORMAL;
            endcase
        end
    end

    always_comb begin
        wait_cnt_nx = wait_cnt;
        if (!b_valid || b_ready)
            wait_cnt_nx = '0;
        else if (wait_cnt != CNT_W'(MAX_WAIT))
            wait_cnt_nx = wait_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= NORMAL;
            wait_cnt <= '0;
            wb_we    <= 1'b0;
            wb_addr  <= '0;
            wb_data  <= '0;
            wb_sel   <= WB_SEL_A;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_cnt_nx;
            if (grant_a || grant_b) begin
                wb_we   <= (sel_addr != ADDR_W'(REG_ZERO));
                wb_addr <= sel_addr;
                wb_data <= sel_data;
                wb_sel  <= grant_b ? WB_SEL_B : WB_SEL_A;
            end else begin
                wb_we   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized and directed bench for wb_port_arbiter against a refusal-count model.
module tb_wb_port_arbiter;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int MAX_WAIT = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              a_valid = 1'b0;
    logic [ADDR_W-1:0] a_rd = '0;
    logic [DATA_W-1:0] a_data = '0;
    logic              b_valid = 1'b0;
    logic [ADDR_W-1:0] b_rd = '0;
    logic [DATA_W-1:0] b_data = '0;
    logic              b_ready, stall_o, wb_we, wb_sel;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;

    always #5 clk = ~clk;

    wb_port_arbiter #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .a_valid (a_valid),
        .a_rd    (a_rd),
        .a_data  (a_data),
        .b_valid (b_valid),
        .b_rd    (b_rd),
        .b_data  (b_data),
        .b_ready (b_ready),
        .stall_o (stall_o),
        .wb_we   (wb_we),
        .wb_addr (wb_addr),
        .wb_data (wb_data),
        .wb_sel  (wb_sel)
    );

    int checks = 0;
    int errors = 0;

    // Model: how many consecutive cycles B has been refused, plus expected write register.
    int                m_refused;
    logic              m_we, m_sel;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_data;
    logic              last_ready, last_stall;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_refused  = 0;
        m_we       = 1'b0;
        m_sel      = 1'b0;
        m_addr     = '0;
        m_data     = '0;
        last_ready = 1'b0;
        last_stall = 1'b0;
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic step();
        logic forced, ga, gb, e_ready, e_stall;
        #1;
        forced = (m_refused >= MAX_WAIT);
        if (forced) begin
            ga      = 1'b0;
            gb      = b_valid;
            e_ready = b_valid;
            e_stall = a_valid & b_valid;
        end else begin
            ga      = a_valid;
            gb      = b_valid & !a_valid;
            e_ready = gb | (a_valid & b_valid & (a_rd == b_rd));
            e_stall = 1'b0;
        end
        check("b_ready", b_ready, e_ready);
        check("stall_o", stall_o, e_stall);
        last_ready = b_ready;
        last_stall = stall_o;
        @(posedge clk);
        if (ga) begin
            m_we = (a_rd != 0); m_addr = a_rd; m_data = a_data; m_sel = 1'b0;
        end else if (gb) begin
            m_we = (b_rd != 0); m_addr = b_rd; m_data = b_data; m_sel = 1'b1;
        end else begin
            m_we = 1'b0;
        end
        if (b_valid && !e_ready)
            m_refused = (m_refused < MAX_WAIT) ? m_refused + 1 : MAX_WAIT;
        else
            m_refused = 0;
        @(negedge clk);
        check("wb_we", wb_we, m_we);
        check("wb_addr", wb_addr, m_addr);
        check("wb_data", wb_data, m_data);
        check("wb_sel", wb_sel, m_sel);
    endtask

    task automatic idle_inputs();
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        a_valid = 1'b1;
        b_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_wb_we", wb_we, 0);
        check("rst_wb_addr", wb_addr, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_wb_sel", wb_sel, 0);
        check("rst_b_ready", b_ready, 0);
        check("rst_stall", stall_o, 0);
        idle_inputs();
        rst = 1'b0;

        // A only
        @(negedge clk);
        a_valid = 1'b1; a_rd = 5'd3; a_data = 32'h11;
        step();
        check("aonly_we", wb_we, 1);
        check("aonly_addr", wb_addr, 3);
        check("aonly_data", wb_data, 32'h11);
        check("aonly_sel", wb_sel, 0);
        check("aonly_ready", last_ready, 0);
        check("aonly_stall", last_stall, 0);
        idle_inputs();

        // B only
        b_valid = 1'b1; b_rd = 5'd7; b_data = 32'hBEEF;
        step();
        check("bonly_ready", last_ready, 1);
        check("bonly_we", wb_we, 1);
        check("bonly_addr", wb_addr, 7);
        check("bonly_sel", wb_sel, 1);
        idle_inputs();

        // Starvation
        a_valid = 1'b1; a_rd = 5'd2; b_valid = 1'b1; b_rd = 5'd5; b_data = 32'h5555;
        for (int i = 0; i < MAX_WAIT; i++) begin
            a_data = 32'h100 + i;
            step();
            check("starve_wait", last_ready, 0);
        end
        step();
        check("starve_ready", last_ready, 1);
        check("starve_stall", last_stall, 1);
        check("starve_sel", wb_sel, 1);
        check("starve_addr", wb_addr, 5);
        b_valid = 1'b0;
        step();
        check("resume_sel", wb_sel, 0);
        check("resume_addr", wb_addr, 2);
        idle_inputs();

        // WAW
        a_valid = 1'b1; b_valid = 1'b1; a_rd = 5'd9; b_rd = 5'd9;
        a_data = 32'hA; b_data = 32'hB;
        step();
        check("waw_ready", last_ready, 1);
        check("waw_addr", wb_addr, 9);
        check("waw_data", wb_data, 32'hA);
        check("waw_sel", wb_sel, 0);
        idle_inputs();
        step();
        check("waw_single", wb_we, 0);

        // Register zero
        b_valid = 1'b1; b_rd = 5'd0; b_data = 32'h77;
        step();
        check("r0_ready", last_ready, 1);
        check("r0_we", wb_we, 0);
        idle_inputs();

        // Reset while STARVED
        a_valid = 1'b1; a_rd = 5'd4; a_data = 32'h44; b_valid = 1'b1; b_rd = 5'd6; b_data = 32'h66;
        for (int i = 0; i < MAX_WAIT; i++) step();
        rst = 1'b1;
        #1;
        check("arst_wb_we", wb_we, 0);
        check("arst_wb_addr", wb_addr, 0);
        check("arst_wb_data", wb_data, 0);
        check("arst_wb_sel", wb_sel, 0);
        check("arst_stall", stall_o, 0);
        check("arst_ready", b_ready, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < MAX_WAIT; i++) begin
            step();
            check("arst_rewait", last_ready, 0);
        end
        step();
        check("arst_forced", last_ready, 1);
        idle_inputs();
        step();

        // Randomized traffic honouring both handshakes
        for (int n = 0; n < 2000; n++) begin
            if (!a_valid || !last_stall) begin
                a_valid = ($urandom_range(0, 99) < 60);
                a_rd    = ADDR_W'($urandom_range(0, 3));
                a_data  = $urandom;
            end
            if (!b_valid || last_ready) begin
                b_valid = ($urandom_range(0, 99) < 40);
                b_rd    = ADDR_W'($urandom_range(0, 3));
                b_data  = $urandom;
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
